// File: rtl/serial_word_assembler_pkg.sv
// Shared definitions for the serial word assembler: FSM state encoding and
// the bit-counter width rule.
package serial_word_assembler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // Bit counter width: enough to hold x-1, but never narrower than one bit.
  function automatic int cnt_width(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/serial_word_assembler_bit_counter.sv
// Frame bit counter. clr_i loads 1 (the start bit is bit #1), inc_i counts one
// more accepted bit. last_o flags that the next accepted bit completes the word.
module serial_word_assembler_bit_counter
  import serial_word_assembler_pkg::*;
#(
  parameter int x = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   inc_i,
  output logic [cnt_width(x)-1:0] count_o,
  output logic                   last_o
);

  localparam int CW = cnt_width(x);
  localparam logic [CW-1:0] LAST_CNT = CW'(x - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = CW'(1);
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == LAST_CNT);

endmodule

// File: rtl/serial_word_assembler.sv
// Serial word assembler: collects a framed serial bit stream into an x-bit
// word and presents it with a one-cycle load pulse for a downstream register.
//
// Input handshake: ser_valid qualifies ser_in (and ser_start) in the cycle it
// is high; there is no ready, every valid bit is consumed on that clock edge.
// Outputs are all registered; data_out only changes on the edge raising load.
module serial_word_assembler
  import serial_word_assembler_pkg::*;
#(
  parameter int x         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ser_in,
  input  logic                    ser_valid,
  input  logic                    ser_start,
  output logic [x-1:0]            data_out,
  output logic                    load,
  output logic                    busy,
  output logic                    frame_err,
  output logic [1:0]              dbg_state,
  output logic [cnt_width(x)-1:0] dbg_count
);

  localparam bit SINGLE_BIT = (x == 1);
  // Where a new bit enters the shift register: top for right shift (LSB
  // first), bottom for left shift (MSB first).
  localparam logic [x-1:0] INS_POS = x'(1) << (MSB_FIRST ? 0 : x - 1);

  state_e         state_q, state_d;
  logic [x-1:0]   sr_q, sr_d;
  logic [x-1:0]   data_q, data_d;
  logic           ferr_q, ferr_d;
  logic           cnt_clr, cnt_inc, cnt_last;
  logic [x-1:0]   sr_fresh, sr_cont;

  // Shift one bit into base in the configured order.
  function automatic logic [x-1:0] shift_in(input logic [x-1:0] base, input logic b);
    logic [x-1:0] ins;
    ins = b ? INS_POS : '0;
    if (MSB_FIRST) begin
      return (base << 1) | ins;
    end else begin
      return (base >> 1) | ins;
    end
  endfunction

  serial_word_assembler_bit_counter #(.x(x)) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (dbg_count),
    .last_o  (cnt_last)
  );

  // Candidate shift values: starting a fresh frame, or continuing the current one.
  always_comb begin
    sr_fresh = shift_in('0, ser_in);
    sr_cont  = shift_in(sr_q, ser_in);
  end

  // FSM next state, shift register, output word and error pulse.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    data_d  = data_q;
    ferr_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      // LOAD accepts input exactly like IDLE, so frames can run back to back.
      ST_IDLE, ST_LOAD: begin
        state_d = ST_IDLE;
        if (ser_valid && ser_start) begin
          sr_d    = sr_fresh;
          cnt_clr = 1'b1;
          if (SINGLE_BIT) begin
            state_d = ST_LOAD;
            data_d  = sr_fresh;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (ser_valid) begin
          if (ser_start) begin
            // Restart: drop the partial word, this bit is bit #1 again.
            sr_d    = sr_fresh;
            cnt_clr = 1'b1;
            ferr_d  = 1'b1;
            if (SINGLE_BIT) begin
              state_d = ST_LOAD;
              data_d  = sr_fresh;
            end
          end else begin
            sr_d    = sr_cont;
            cnt_inc = 1'b1;
            if (cnt_last) begin
              state_d = ST_LOAD;
              data_d  = sr_cont;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign load      = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_SHIFT);
  assign frame_err = ferr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: three instances (x=4 LSB-first, x=4
// MSB-first, x=1) share one serial stream. A frame-level reference model
// predicts completed words and abandoned frames into queues; a negedge
// monitor pops and compares whenever a DUT presents load or frame_err.
module tb_serial_word_assembler;

  localparam int N = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_in = 1'b0, ser_valid = 1'b0, ser_start = 1'b0;
  always #5 clk = ~clk;

  int xs   [N] = '{4, 4, 1};
  int msbf [N] = '{0, 1, 0};

  // ---------------- DUTs ----------------
  logic [3:0] d0, d1;
  logic [0:0] d2;
  logic       l0, l1, l2, b0, b1, b2, f0, f1, f2;
  logic [1:0] s0, s1, s2;
  logic [1:0] c0, c1;
  logic [0:0] c2;

  serial_word_assembler #(.x(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_start(ser_start),
    .data_out(d0), .load(l0), .busy(b0), .frame_err(f0), .dbg_state(s0), .dbg_count(c0));

  serial_word_assembler #(.x(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_start(ser_start),
    .data_out(d1), .load(l1), .busy(b1), .frame_err(f1), .dbg_state(s1), .dbg_count(c1));

  serial_word_assembler #(.x(1), .MSB_FIRST(1'b0)) u_one (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_start(ser_start),
    .data_out(d2), .load(l2), .busy(b2), .frame_err(f2), .dbg_state(s2), .dbg_count(c2));

  logic [3:0] dout [N];
  logic       ld   [N];
  logic       bsy  [N];
  logic       fe   [N];
  assign dout[0] = d0;
  assign dout[1] = d1;
  assign dout[2] = {3'b000, d2};
  assign ld[0] = l0;  assign ld[1] = l1;  assign ld[2] = l2;
  assign bsy[0] = b0; assign bsy[1] = b1; assign bsy[2] = b2;
  assign fe[0] = f0;  assign fe[1] = f1;  assign fe[2] = f2;

  // Downstream parallel load register fed by the LSB-first instance.
  logic [3:0] ds_q;
  always @(posedge clk or posedge rst) begin
    if (rst) ds_q <= 4'h0;
    else if (l0) ds_q <= d0;
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int         inst;
    logic [3:0] w;
    int         cyc;
  } ev_t;

  ev_t        exp_q [$];
  ev_t        err_q [$];
  int         nbits  [N];
  logic [3:0] acc    [N];
  logic [3:0] last_w [N];
  int         tick;
  int         n_checks;
  int         n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at tick %0d: got 0x%0h, expected 0x%0h", name, tick, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      nbits[i]  = 0;
      acc[i]    = 4'h0;
      last_w[i] = 4'h0;
    end
    exp_q.delete();
    err_q.delete();
  endtask

  // Frame-level model: a frame is the list of bits since the last start.
  task automatic model_bit(input int i, input bit s, input bit b);
    ev_t e;
    int  pos;
    if (s) begin
      if (nbits[i] > 0) begin
        e.inst = i; e.w = 4'h0; e.cyc = tick;
        err_q.push_back(e);
      end
      nbits[i] = 0;
      acc[i]   = 4'h0;
    end else if (nbits[i] == 0) begin
      return;
    end
    pos = msbf[i] ? (xs[i] - 1 - nbits[i]) : nbits[i];
    acc[i][pos] = b;
    nbits[i]++;
    if (nbits[i] == xs[i]) begin
      e.inst = i; e.w = acc[i]; e.cyc = tick;
      exp_q.push_back(e);
      last_w[i] = acc[i];
      nbits[i]  = 0;
    end
  endtask

  // Match one DUT event (load or frame_err) of instance i against its queue.
  task automatic match(input int i, input bit is_err, input bit seen);
    int    found;
    ev_t   e;
    string tag;
    found = -1;
    tag   = is_err ? "frame_err" : "load";
    if (is_err) begin
      for (int j = 0; j < err_q.size(); j++)
        if (err_q[j].inst == i && err_q[j].cyc <= tick) begin found = j; break; end
      if (found >= 0) begin e = err_q[found]; err_q.delete(found); end
    end else begin
      for (int j = 0; j < exp_q.size(); j++)
        if (exp_q[j].inst == i && exp_q[j].cyc <= tick) begin found = j; break; end
      if (found >= 0) begin e = exp_q[found]; exp_q.delete(found); end
    end
    chk($sformatf("u%0d_%s_present", i, tag), int'(seen), int'(found >= 0));
    if (seen && found >= 0) begin
      chk($sformatf("u%0d_%s_cycle", i, tag), tick, e.cyc);
      if (!is_err) chk($sformatf("u%0d_load_word", i), int'(dout[i]), int'(e.w));
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      match(i, 1'b0, ld[i]);
      match(i, 1'b1, fe[i]);
      chk($sformatf("u%0d_busy", i), int'(bsy[i]), int'(nbits[i] > 0));
      chk($sformatf("u%0d_data_out", i), int'(dout[i]), int'(last_w[i]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input bit s, input bit b);
    ser_valid = v;
    ser_start = s;
    ser_in    = b;
    @(posedge clk);
    tick++;
    if (!rst && v) begin
      for (int i = 0; i < N; i++) model_bit(i, s, b);
    end
    #1;
    ser_valid = 1'b0;
    ser_start = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Send nbit bits of word w in transmit order (bit[0] first), start on first.
  task automatic send_frame(input logic [3:0] bits, input int gaps);
    logic [3:0] t;
    t = bits;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, k == 0, t[k]);
      if (k < 3) gap(gaps);
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d_rst_data", i), int'(dout[i]), 0);
      chk($sformatf("u%0d_rst_load", i), int'(ld[i]), 0);
      chk($sformatf("u%0d_rst_busy", i), int'(bsy[i]), 0);
      chk($sformatf("u%0d_rst_ferr", i), int'(fe[i]), 0);
    end
    model_clear();
    @(posedge clk);
    tick++;
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    tick     = 0;
    model_clear();
    #1;
    do_reset();
    gap(2);

    // Bits 1,0,1,1 back to back: LSB-first 4'hD, MSB-first 4'hB.
    send_frame(4'b1101, 0);
    gap(1);
    chk("lsb_word_D", int'(d0), 4'hD);
    chk("msb_word_B", int'(d1), 4'hB);
    chk("downstream_q_D", int'(ds_q), 4'hD);

    // Same bits with two-cycle gaps.
    send_frame(4'b1101, 2);
    gap(2);
    chk("gap_msb_word_B", int'(d1), 4'hB);

    // Abandoned frame: 1,1 then restart with 0,0,1,0.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    send_frame(4'b0100, 0);
    gap(2);
    chk("restart_lsb_word_4", int'(d0), 4'h4);

    // Back-to-back frames 4'hA then 4'h5, second start in the LOAD cycle.
    send_frame(4'hA, 0);
    send_frame(4'h5, 0);
    gap(2);
    chk("b2b_lsb_word_5", int'(d0), 4'h5);

    // Reset after three bits, then a stray bit, then a full frame 4'h3.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    do_reset();
    step(1'b1, 1'b0, 1'b1);
    gap(1);
    send_frame(4'h3, 0);
    gap(2);
    chk("post_reset_lsb_word_3", int'(d0), 4'h3);

    // Random stream: gaps, restarts, stray bits.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
    end
    gap(3);

    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_q_drained", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
